// File: rtl/gpu_mem_responder.sv
// VRAM block responder: PIXEL2VRAM/FILL block writes, 8-beat read and write bursts.
// Optional build macro GPU_MEM_SKIP_MASKED_EN skips fully masked PIXEL2VRAM beats.
module gpu_mem_responder (
  input  logic         clk,
  input  logic         i_nrst,
  input  logic [2:0]   i_command,
  input  logic         i_commandValid,
  output logic         o_commandReady,
  input  logic [14:0]  i_blockAdr,
  input  logic [255:0] i_pixels,
  input  logic [15:0]  i_pixelMask,
  input  logic [15:0]  i_fillColor,
  input  logic [31:0]  i_wrData,
  input  logic         i_wrValid,
  output logic         o_wrReady,
  output logic [31:0]  o_rdData,
  output logic         o_rdValid,
  output logic [17:0]  o_memAdr,
  output logic         o_memWrite,
  output logic         o_memRead,
  output logic [3:0]   o_memByteEn,
  output logic [31:0]  o_memWData,
  input  logic         i_memBusy,
  input  logic [31:0]  i_memRData,
  input  logic         i_memRValid,
  output logic         o_busy,
  output logic [2:0]   o_dbgState
);

  localparam logic [2:0] CMD_PIXEL2VRAM = 3'b001;
  localparam logic [2:0] CMD_FILL       = 3'b010;
  localparam logic [2:0] CMD_RDBURST    = 3'b011;
  localparam logic [2:0] CMD_WRBURST    = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WR_BLOCK  = 3'd1,
    S_RD_REQ    = 3'd2,
    S_RD_WAIT   = 3'd3,
    S_WR_STREAM = 3'd4
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [2:0]     r_cmd;
  logic [14:0]    r_adr;
  logic [255:0]   r_pixels;
  logic [15:0]    r_mask;
  logic [15:0]    r_color;
  logic [2:0]     r_beat, w_beat_nxt;
  logic [3:0]     r_rcnt;
  logic [31:0]    r_rdData;
  logic           r_rdValid;
  logic           w_accept;
  logic           w_rv;
  logic [3:0]     w_rcnt_next;
  logic [1:0]     w_beat_mask;

`ifdef GPU_MEM_SKIP_MASKED_EN
  logic [7:0]     w_in_pairs;
  logic [7:0]     w_eff_pairs;
  logic [3:0]     w_first;
  logic [3:0]     w_next;

  // Lowest set pair index at or above start; 8 means none left.
  function automatic logic [3:0] find_from(input logic [7:0] pairs, input logic [3:0] start);
    logic [3:0] res;
    res = 4'd8;
    for (int i = 7; i >= 0; i--) begin
      if (pairs[i] && (4'(i) >= start)) res = 4'(i);
    end
    return res;
  endfunction

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      w_in_pairs[k]  = i_pixelMask[2*k] | i_pixelMask[2*k+1];
      w_eff_pairs[k] = (r_cmd == CMD_FILL) | r_mask[2*k] | r_mask[2*k+1];
    end
  end
  assign w_first = find_from(w_in_pairs, 4'd0);
  assign w_next  = find_from(w_eff_pairs, {1'b0, r_beat} + 4'd1);
`endif

  assign o_commandReady = (r_state == S_IDLE) && i_nrst;
  assign o_busy         = (r_state != S_IDLE);
  assign o_dbgState     = r_state;
  assign o_rdData       = r_rdData;
  assign o_rdValid      = r_rdValid;
  assign w_accept       = i_commandValid && o_commandReady;
  // Returns count from the first read request onward, not only after RD_REQ ends.
  assign w_rv           = i_memRValid && ((r_state == S_RD_REQ) || (r_state == S_RD_WAIT));
  assign w_rcnt_next    = r_rcnt + {3'b000, w_rv};
  assign w_beat_mask    = r_mask[{r_beat, 1'b0} +: 2];

  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    o_memAdr    = 18'd0;
    o_memWrite  = 1'b0;
    o_memRead   = 1'b0;
    o_memByteEn = 4'd0;
    o_memWData  = 32'd0;
    o_wrReady   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_beat_nxt = 3'd0;
          case (i_command)
            CMD_PIXEL2VRAM: begin
`ifdef GPU_MEM_SKIP_MASKED_EN
              if (!w_first[3]) begin
                w_state_nxt = S_WR_BLOCK;
                w_beat_nxt  = w_first[2:0];
              end
`else
              w_state_nxt = S_WR_BLOCK;
`endif
            end
            CMD_FILL:    w_state_nxt = S_WR_BLOCK;
            CMD_RDBURST: w_state_nxt = S_RD_REQ;
            CMD_WRBURST: w_state_nxt = S_WR_STREAM;
            default:     w_state_nxt = S_IDLE;
          endcase
        end
      end
      S_WR_BLOCK: begin
        o_memWrite = 1'b1;
        o_memAdr   = {r_adr, r_beat};
        if (r_cmd == CMD_FILL) begin
          o_memWData  = {r_color, r_color};
          o_memByteEn = 4'hF;
        end else begin
          o_memWData  = r_pixels[{r_beat, 5'b00000} +: 32];
          o_memByteEn = {{2{w_beat_mask[1]}}, {2{w_beat_mask[0]}}};
        end
        if (!i_memBusy) begin
`ifdef GPU_MEM_SKIP_MASKED_EN
          if (w_next[3]) begin
            w_state_nxt = S_IDLE;
            w_beat_nxt  = 3'd0;
          end else begin
            w_beat_nxt  = w_next[2:0];
          end
`else
          w_beat_nxt = r_beat + 3'd1;
          if (r_beat == 3'd7) w_state_nxt = S_IDLE;
`endif
        end
      end
      S_RD_REQ: begin
        o_memRead = 1'b1;
        o_memAdr  = {r_adr, r_beat};
        if (!i_memBusy) begin
          w_beat_nxt = r_beat + 3'd1;
          if (r_beat == 3'd7) w_state_nxt = (w_rcnt_next == 4'd8) ? S_IDLE : S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (w_rcnt_next == 4'd8) w_state_nxt = S_IDLE;
      end
      S_WR_STREAM: begin
        o_memWrite  = i_wrValid;
        o_memAdr    = {r_adr, r_beat};
        o_memWData  = i_wrData;
        o_memByteEn = 4'hF;
        o_wrReady   = !i_memBusy;
        if (i_wrValid && !i_memBusy) begin
          w_beat_nxt = r_beat + 3'd1;
          if (r_beat == 3'd7) w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state   <= S_IDLE;
      r_cmd     <= 3'd0;
      r_adr     <= 15'd0;
      r_pixels  <= 256'd0;
      r_mask    <= 16'd0;
      r_color   <= 16'd0;
      r_beat    <= 3'd0;
      r_rcnt    <= 4'd0;
      r_rdValid <= 1'b0;
      r_rdData  <= 32'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_beat    <= w_beat_nxt;
      r_rdValid <= w_rv;
      if (w_rv) r_rdData <= i_memRData;
      if (w_accept) begin
        r_cmd    <= i_command;
        r_adr    <= i_blockAdr;
        r_pixels <= i_pixels;
        r_mask   <= i_pixelMask;
        r_color  <= i_fillColor;
        r_rcnt   <= 4'd0;
      end else if (w_rv) begin
        r_rcnt   <= w_rcnt_next;
      end
    end
  end

endmodule

// File: tb/tb_gpu_mem_responder.sv
// Directed bench for gpu_mem_responder: block writes, read/write bursts, reset abort.
// Expectations follow GPU_MEM_SKIP_MASKED_EN when the bench is built with it.
module tb_gpu_mem_responder;

  logic         clk = 1'b0;
  logic         i_nrst;
  logic [2:0]   i_command;
  logic         i_commandValid;
  logic         o_commandReady;
  logic [14:0]  i_blockAdr;
  logic [255:0] i_pixels;
  logic [15:0]  i_pixelMask;
  logic [15:0]  i_fillColor;
  logic [31:0]  i_wrData;
  logic         i_wrValid;
  logic         o_wrReady;
  logic [31:0]  o_rdData;
  logic         o_rdValid;
  logic [17:0]  o_memAdr;
  logic         o_memWrite;
  logic         o_memRead;
  logic [3:0]   o_memByteEn;
  logic [31:0]  o_memWData;
  logic         i_memBusy;
  logic [31:0]  i_memRData;
  logic         i_memRValid;
  logic         o_busy;
  logic [2:0]   o_dbgState;

  gpu_mem_responder dut (
    .clk(clk), .i_nrst(i_nrst), .i_command(i_command), .i_commandValid(i_commandValid),
    .o_commandReady(o_commandReady), .i_blockAdr(i_blockAdr), .i_pixels(i_pixels),
    .i_pixelMask(i_pixelMask), .i_fillColor(i_fillColor), .i_wrData(i_wrData),
    .i_wrValid(i_wrValid), .o_wrReady(o_wrReady), .o_rdData(o_rdData), .o_rdValid(o_rdValid),
    .o_memAdr(o_memAdr), .o_memWrite(o_memWrite), .o_memRead(o_memRead),
    .o_memByteEn(o_memByteEn), .o_memWData(o_memWData), .i_memBusy(i_memBusy),
    .i_memRData(i_memRData), .i_memRValid(i_memRValid), .o_busy(o_busy), .o_dbgState(o_dbgState)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  int n_checks = 0;
  int n_err    = 0;

  logic [53:0] exp_q[$];
  logic [53:0] wr_q[$];
  logic [31:0] rd_q[$];
  logic [17:0] rdadr_q[$];
  int          n_reads = 0;
  logic        rd_chk_en = 1'b0;
  logic        last_rv = 1'b0;
  logic        rv_inject = 1'b0;
  logic [2:0]  pv = 3'b000;
  logic [31:0] pd[3];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // memory model: read data 0xA0+beat returned 3 cycles after the request completes
  always @(negedge clk) begin
    logic        v_out;
    logic [31:0] d_out;
    v_out = pv[2];
    d_out = pd[2];
    pv[2] = pv[1];  pd[2] = pd[1];
    pv[1] = pv[0];  pd[1] = pd[0];
    pv[0] = o_memRead && !i_memBusy;
    pd[0] = 32'hA0 + {29'd0, o_memAdr[2:0]};
    i_memRValid = v_out | rv_inject;
    i_memRData  = d_out;
  end

  // monitor: logs completed beats and the read return stream
  always @(negedge clk) begin
    #3;
    if (o_memWrite && !i_memBusy) wr_q.push_back({o_memAdr, o_memByteEn, o_memWData});
    if (o_memRead && !i_memBusy) begin
      n_reads++;
      rdadr_q.push_back(o_memAdr);
    end
    if (rd_chk_en) begin
      check("rd_latency", {63'd0, o_rdValid}, {63'd0, last_rv});
      if (o_rdValid) begin
        rd_q.push_back(o_rdData);
        if (rd_q.size() == 8) check("rd_idle_after_8", {63'd0, o_busy}, 64'd0);
      end
    end
    last_rv = i_memRValid;
  end

  // driver tasks
  task automatic send_cmd(input logic [2:0] cmd, input logic [14:0] adr, input logic [255:0] pix,
                          input logic [15:0] mask, input logic [15:0] color);
    int cnt;
    @(negedge clk);
    i_command = cmd; i_blockAdr = adr; i_pixels = pix; i_pixelMask = mask; i_fillColor = color;
    i_commandValid = 1'b1;
    cnt = 0;
    while (!o_commandReady && cnt < 30) begin
      @(negedge clk);
      cnt++;
    end
    if (!o_commandReady) check("cmd_accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1 i_commandValid = 1'b0;
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!o_commandReady && cyc < 40);
    #4;
  endtask

  task automatic compare_writes(input string tag);
    int n;
    check({tag, "_count"}, 64'(wr_q.size()), 64'(exp_q.size()));
    n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_w%0d", tag, i), 64'(wr_q[i]), 64'(exp_q[i]));
    wr_q.delete();
    exp_q.delete();
  endtask

  task automatic run_pixel(input logic [14:0] adr, input logic [15:0] mask, input logic [15:0] base,
                           input int busy_cycles, input string tag);
    logic [255:0] pix;
    logic [1:0]   pr;
    int           cyc;
    for (int k = 0; k < 16; k++) pix[16*k +: 16] = base + 16'(k);
    for (int k = 0; k < 8; k++) begin
      pr = mask[2*k +: 2];
`ifdef GPU_MEM_SKIP_MASKED_EN
      if (pr != 2'b00)
`endif
        exp_q.push_back({adr, 3'(k), {2{pr[1]}}, {2{pr[0]}}, pix[32*k +: 32]});
    end
    wr_q.delete();
    i_memBusy = (busy_cycles > 0);
    send_cmd(3'b001, adr, pix, mask, 16'h0);
    if (busy_cycles > 0) begin
      repeat (busy_cycles) @(negedge clk);
      i_memBusy = 1'b0;
    end
    wait_ready(cyc);
    compare_writes(tag);
  endtask

  initial begin
    int cyc, w, bl, c;
    logic bub, busy, val;
    pd[0] = '0; pd[1] = '0; pd[2] = '0;
    i_nrst = 1'b0; i_command = 3'd0; i_commandValid = 1'b0; i_blockAdr = '0;
    i_pixels = '0; i_pixelMask = '0; i_fillColor = '0; i_wrData = '0; i_wrValid = 1'b0;
    i_memBusy = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    #1 check("reset_outputs",
             64'({o_busy, o_memWrite, o_memRead, o_memByteEn, o_memAdr, o_memWData, o_wrReady}), 64'd0);
    check("reset_rd", {31'd0, o_rdValid, o_rdData}, 64'd0);
    @(negedge clk) i_nrst = 1'b1;
    #1 check("ready_after_reset", {63'd0, o_commandReady}, 64'd1);

    // NONE and reserved codes stay idle with no traffic
    wr_q.delete(); n_reads = 0;
    send_cmd(3'b000, 15'h0011, '0, 16'hFFFF, 16'h1111);
    @(negedge clk);
    check("none_busy", {63'd0, o_busy}, 64'd0);
    send_cmd(3'b110, 15'h0011, '0, 16'hFFFF, 16'h1111);
    @(negedge clk);
    check("rsvd_ready", {63'd0, o_commandReady}, 64'd1);
    repeat (2) @(negedge clk);
    #4 check("none_traffic", 64'(wr_q.size() + n_reads), 64'd0);

    // FILL: 8 writes, mask ignored, ready again after 9 cycles
    for (int i = 0; i < 8; i++) exp_q.push_back({18'h00080 + 18'(i), 4'hF, 32'h7FFF7FFF});
    send_cmd(3'b010, 15'h0010, '0, 16'h0000, 16'h7FFF);
    wait_ready(cyc);
    check("fill_ready_cycles", 64'(cyc), 64'd9);
    compare_writes("fill");

    // PIXEL2VRAM
    run_pixel(15'h0000, 16'h0003, 16'h1000, 0, "pix_m0003");
    run_pixel(15'h7FFF, 16'h8421, 16'h2000, 2, "pix_m8421");

    // WRBURST with a 2-cycle stall on beat 3 and a bubble on beat 5
    for (int i = 0; i < 8; i++) exp_q.push_back({15'h1234, 3'(i), 4'hF, 32'hD0000000 + 32'(i)});
    send_cmd(3'b100, 15'h1234, '0, 16'h0, 16'h0);
    w = 0; bl = 2; bub = 1'b0; c = 0;
    while (w < 8 && c < 40) begin
      @(negedge clk);
      c++;
      busy = (w == 3 && bl > 0);
      if (busy) bl--;
      val = !(w == 5 && !bub);
      if (!val) bub = 1'b1;
      i_memBusy = busy; i_wrValid = val; i_wrData = 32'hD0000000 + 32'(w);
      #1 check("wr_ready", {63'd0, o_wrReady}, {63'd0, !busy});
      @(posedge clk);
      if (val && !busy) w++;
    end
    if (w < 8) check("wr_timeout", 64'(w), 64'd8);
    #1 i_wrValid = 1'b0; i_memBusy = 1'b0;
    @(negedge clk);
    check("wr_ready_idle", {63'd0, o_wrReady}, 64'd0);
    check("wr_busy_idle", {63'd0, o_busy}, 64'd0);
    #4 compare_writes("wrburst");

    // RDBURST adr 1, 3-cycle memory latency
    rd_q.delete(); rdadr_q.delete();
    rd_chk_en = 1'b1;
    send_cmd(3'b011, 15'h0001, '0, 16'h0, 16'h0);
    c = 0;
    while (rd_q.size() < 8 && c < 60) begin
      @(negedge clk);
      c++;
      #4;
    end
    repeat (2) @(negedge clk);
    #4 rd_chk_en = 1'b0;
    check("rd_count", 64'(rd_q.size()), 64'd8);
    for (int i = 0; i < rd_q.size(); i++) check($sformatf("rd_data%0d", i), 64'(rd_q[i]), 64'hA0 + 64'(i));
    check("rd_req_count", 64'(rdadr_q.size()), 64'd8);
    for (int i = 0; i < rdadr_q.size(); i++) check($sformatf("rd_adr%0d", i), 64'(rdadr_q[i]), 64'h8 + 64'(i));

    // stray read data while idle is ignored
    @(negedge clk); #1 rv_inject = 1'b1;
    @(negedge clk); #1 rv_inject = 1'b0;
    @(negedge clk); #3 check("rv_ignored", {63'd0, o_rdValid}, 64'd0);

    // reset during beat 4 of FILL
    wr_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back({18'h00100 + 18'(i), 4'hF, 32'h12341234});
    send_cmd(3'b010, 15'h0020, '0, 16'h0, 16'h1234);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!(o_memWrite && o_memAdr[2:0] == 3'd4) && c < 20);
    i_nrst = 1'b0;
    #1 check("rst_mid_outputs",
             64'({o_busy, o_memWrite, o_memRead, o_memByteEn, o_memAdr, o_memWData, o_wrReady}), 64'd0);
    repeat (2) @(negedge clk);
    i_nrst = 1'b1;
    repeat (3) @(negedge clk);
    #4 check("rst_mid_idle", {63'd0, o_busy}, 64'd0);
    compare_writes("rst_fill");
    for (int i = 0; i < 8; i++) exp_q.push_back({18'h00100 + 18'(i), 4'hF, 32'h0F0F0F0F});
    send_cmd(3'b010, 15'h0020, '0, 16'h0, 16'h0F0F);
    wait_ready(cyc);
    compare_writes("post_rst_fill");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
